// File: rtl/bp_pkg.sv
// Shared types for the branch history table: counter encodings,
// table entry layout and PC step.
package bp_pkg;

    localparam int BHT_INDEX_BITS = 6;
    localparam int BHT_TAG_BITS   = 10;

    localparam logic [63:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    typedef struct packed {
        logic                    valid;
        logic [BHT_TAG_BITS-1:0] tag;
        cnt_e                    cnt;
        logic [63:0]             target;
    } bht_entry_t;

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Next value of a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  cnt_e cnt_i,
    input  logic inc_i,
    output cnt_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        unique case (cnt_i)
            SNT: cnt_o = inc_i ? WNT : SNT;
            WNT: cnt_o = inc_i ? WT  : SNT;
            WT:  cnt_o = inc_i ? ST  : WNT;
            ST:  cnt_o = inc_i ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT/BTB: same-cycle fetch lookup, EX-side training
// and a registered flush/redirect on mispredict.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BHT_INDEX_BITS,
    parameter int TAG_BITS   = BHT_TAG_BITS,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [63:0]          pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_branch,
    input  logic [63:0]          ex_pc,
    input  logic                 ex_taken,
    input  logic [63:0]          ex_target,
    input  logic                 ex_pred_taken,
    input  logic [63:0]          ex_pred_target,
    output logic                 flush,
    output logic [63:0]          redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    bht_entry_t tbl_q [DEPTH];
    bht_entry_t tbl_d [DEPTH];

    logic                 flush_q, flush_d;
    logic [63:0]          redirect_q, redirect_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    bht_entry_t            if_e, ex_e;
    logic                  if_hit, ex_hit;
    logic                  upd, mispredict;
    cnt_e                  cnt_next;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];

    // Lookup reads the registered table, so a same-cycle update is not seen
    assign if_e   = tbl_q[if_idx];
    assign if_hit = if_e.valid && (if_e.tag == if_tag);
    assign ex_e   = tbl_q[ex_idx];
    assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

    assign pred_hit    = if_hit;
    assign pred_taken  = if_hit && if_e.cnt[1];
    assign pred_target = pred_taken ? if_e.target : if_pc + PC_STEP;

    assign upd        = ex_valid && ex_branch;
    assign mispredict = upd && ((ex_pred_taken != ex_taken) ||
                        (ex_pred_taken && ex_taken &&
                         (ex_pred_target != ex_target)));

    sat_counter2 u_sat (
        .cnt_i (ex_e.cnt),
        .inc_i (ex_taken),
        .cnt_o (cnt_next)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (upd) begin
            if (ex_hit) begin
                tbl_d[ex_idx].cnt = cnt_next;
                if (ex_taken) tbl_d[ex_idx].target = ex_target;
            end else begin
                tbl_d[ex_idx].valid  = 1'b1;
                tbl_d[ex_idx].tag    = ex_tag;
                tbl_d[ex_idx].cnt    = ex_taken ? WT : WNT;
                tbl_d[ex_idx].target = ex_taken ? ex_target : 64'd0;
            end
        end
    end

    always_comb begin
        flush_d    = mispredict;
        redirect_d = redirect_q;
        if (mispredict) redirect_d = ex_taken ? ex_target : ex_pc + PC_STEP;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd && br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
        if (mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].cnt    <= WNT;
                tbl_q[i].target <= '0;
            end
            flush_q    <= 1'b0;
            redirect_q <= '0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
        end else begin
            tbl_q      <= tbl_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
        end
    end

    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;

endmodule
